// File: rtl/jt12_pg_regs_pkg.sv
// jt12_pg_regs_pkg: register addresses, slot count and slot-index helper
package jt12_pg_regs_pkg;
   localparam int SLOTS = 24;
   localparam logic [7:0] REG_KON   = 8'h28;
   localparam logic [7:0] REG_DTMUL = 8'h30;
   localparam logic [7:0] REG_FNLO  = 8'hA0;
   localparam logic [7:0] REG_FNHI  = 8'hA4;
   typedef logic [4:0] slot_t;
   function automatic slot_t slot_idx(input logic [1:0] opidx, input logic part, input logic [1:0] ch);
      return slot_t'(5'(opidx) * 5'd6 + (part ? 5'd3 : 5'd0) + 5'(ch));
   endfunction
endpackage

// File: rtl/jt12_pg_regs_if.sv
// jt12_pg_regs_if: CPU register-write bus into the phase-generator register file
interface jt12_pg_regs_if;
   logic       wr;
   logic       part;
   logic [7:0] addr;
   logic [7:0] din;
   modport master (output wr, part, addr, din);
   modport slave  (input  wr, part, addr, din);
endinterface

// File: rtl/jt12_pg_regs.sv
// jt12_pg_regs: phase-generator register file and 24-slot sequencer
module jt12_pg_regs
   import jt12_pg_regs_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   jt12_pg_regs_if.slave bus,
   output logic [10:0]   fnum_I,
   output logic [2:0]    block_I,
   output logic [2:0]    dt1_II,
   output logic          keyon_II,
   output logic [3:0]    mul_V,
   output logic          zero
);
   logic [10:0]      r_fnum [6];
   logic [2:0]       r_block [6];
   logic [5:0]       r_latch [2];
   logic [2:0]       r_dt1 [SLOTS];
   logic [3:0]       r_mul [SLOTS];
   logic [SLOTS-1:0] r_key, r_pend;
   slot_t            r_cnt, r_slot_I, r_slot_II, r_slot_III, r_slot_IV;
   logic [1:0]       w_ch;
   logic [2:0]       w_chan, w_cch;
   logic             w_fnlo, w_fnhi, w_dtmul, w_kon;
   slot_t            w_dslot;
   slot_t            w_kslot [4];
   logic [3:0]       w_kbits;
   assign w_ch    = bus.addr[1:0];
   assign w_chan  = bus.part ? 3'd3 + {1'b0, w_ch} : {1'b0, w_ch};
   assign w_cch   = 3'(r_cnt % 5'd6);
   assign w_fnlo  = bus.wr && bus.addr[7:2] == REG_FNLO[7:2] && w_ch != 2'd3;
   assign w_fnhi  = bus.wr && bus.addr[7:2] == REG_FNHI[7:2] && w_ch != 2'd3;
   assign w_dtmul = bus.wr && bus.addr[7:4] == REG_DTMUL[7:4] && w_ch != 2'd3;
   assign w_dslot = slot_idx(bus.addr[3:2], bus.part, w_ch);
   assign w_kon   = bus.wr && bus.addr == REG_KON && bus.din[1:0] != 2'd3;
   // key bits come as S1,S2,S3,S4 while slots are ordered S1,S3,S2,S4
   assign w_kbits = {bus.din[7], bus.din[5], bus.din[6], bus.din[4]};
   always_comb
      for (int k = 0; k < 4; k++) w_kslot[k] = slot_idx(2'(k), bus.din[2], bus.din[1:0]);
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 6; i++) begin
            r_fnum[i]  <= '0;
            r_block[i] <= '0;
         end
         for (int i = 0; i < SLOTS; i++) begin
            r_dt1[i] <= '0;
            r_mul[i] <= '0;
         end
         r_latch[0] <= '0;
         r_latch[1] <= '0;
         r_key      <= '0;
         r_pend     <= '0;
         r_cnt      <= '0;
         r_slot_I   <= '0;
         r_slot_II  <= '0;
         r_slot_III <= '0;
         r_slot_IV  <= '0;
         fnum_I     <= '0;
         block_I    <= '0;
         dt1_II     <= '0;
         keyon_II   <= 1'b0;
         mul_V      <= '0;
         zero       <= 1'b0;
      end else begin
         r_cnt      <= r_cnt == 5'(SLOTS - 1) ? '0 : r_cnt + 5'd1;
         r_slot_I   <= r_cnt;
         r_slot_II  <= r_slot_I;
         r_slot_III <= r_slot_II;
         r_slot_IV  <= r_slot_III;
         fnum_I     <= r_fnum[w_cch];
         block_I    <= r_block[w_cch];
         zero       <= r_cnt == '0;
         dt1_II     <= r_dt1[r_slot_I];
         keyon_II   <= r_pend[r_slot_I];
         mul_V      <= r_mul[r_slot_IV];
         r_pend[r_slot_I] <= 1'b0;
         if (w_fnhi) r_latch[bus.part] <= bus.din[5:0];
         if (w_fnlo) begin
            r_fnum[w_chan]  <= {r_latch[bus.part][2:0], bus.din};
            r_block[w_chan] <= r_latch[bus.part][5:3];
         end
         if (w_dtmul) begin
            r_dt1[w_dslot] <= bus.din[6:4];
            r_mul[w_dslot] <= bus.din[3:0];
         end
         // a fresh key-on overrides the stage-II clear so the pulse lands on the next visit
         if (w_kon)
            for (int k = 0; k < 4; k++) begin
               r_key[w_kslot[k]] <= w_kbits[k];
               if (w_kbits[k] && !r_key[w_kslot[k]]) r_pend[w_kslot[k]] <= 1'b1;
            end
      end
   end
endmodule
